atm_auth_sequencer: RTL
=======================

// Module: atm_auth_sequencer
// PURPOSE
//  Sequences customer authentication between card scan and transaction processing in the ATM controller.
//  - Runs PIN entry with a retry limit.
//  - Applies a high-value check that adds face capture and mobile OTP.
//  - Times out stalled steps; locks the card after repeated PIN failures.
//  - Issues a single grant or deny pulse to the main ATM FSM.
// PARAMETERS
//  MAX_PIN_TRIES   3        wrong PINs allowed before lockout (1..7)
//  HIGH_VALUE_AMT  10000    amount > this needs face+OTP
//  TIMEOUT_CYC     1000     cycles allowed per wait step before deny (>=2)
//  AMT_W           16       amount width
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      asynchronous, active-low reset
//  start          in   1      pulse: card scanned, begin auth
//  abort          in   1      customer cancel; priority over all inputs
//  pin_valid      in   1      PIN entry complete this cycle
//  pin_match      in   1      qualifies pin_valid: PIN correct
//  amount         in   AMT_W  requested amount, sampled on amount_valid
//  amount_valid   in   1      amount confirmed this cycle
//  face_done      in   1      face capture finished; face_ok qualifies
//  face_ok        in   1      face recognised
//  otp_valid      in   1      OTP entered; otp_ok qualifies
//  otp_ok         in   1      OTP correct
//  prompt_pin     out  1      level: waiting for PIN
//  capture_face   out  1      level: face capture active
//  prompt_otp     out  1      level: waiting for OTP
//  auth_ok        out  1      1-cycle pulse: grant
//  auth_fail      out  1      1-cycle pulse: deny (wrong OTP/face, timeout, abort)
//  card_retain    out  1      level: card locked/retained
//  tries_left     out  3      remaining PIN attempts
//  busy           out  1      high in every state except IDLE
// BEHAVIOUR
//  - Reset: state IDLE; every output 0, except tries_left = MAX_PIN_TRIES.
//  - All outputs are registered and change on the cycle after the causing input.
//  - States and transitions:
//    - IDLE: start -> PIN_WAIT; load tries_left = MAX_PIN_TRIES and clear timer.
//    - PIN_WAIT (prompt_pin):
//      - pin_valid & pin_match -> AMT_WAIT.
//      - pin_valid & !pin_match: tries_left-1. If result is 0 -> LOCKED, else stay (timer cleared).
//    - AMT_WAIT: amount_valid -> FACE_WAIT if amount > HIGH_VALUE_AMT (strict, unsigned), else GRANT.
//    - FACE_WAIT (capture_face): face_done & face_ok -> OTP_WAIT; face_done & !face_ok -> DENY.
//    - OTP_WAIT (prompt_otp): otp_valid & otp_ok -> GRANT; otp_valid & !otp_ok -> DENY.
//    - GRANT: auth_ok=1 for one cycle -> IDLE.
//    - DENY: auth_fail=1 for one cycle -> IDLE.
//    - LOCKED: card_retain=1, auth_fail pulses once on entry; exits only on reset.
//  - Timeout: each wait state counts cycles from entry. At count == TIMEOUT_CYC-1 with no qualifying
//    input -> DENY. A qualifying input on that same cycle wins over the timeout.
//  - abort in any wait state -> DENY next cycle. abort and start are ignored in IDLE, GRANT, DENY, LOCKED.
//  - start while busy is ignored. Qualifier inputs (pin_match etc.) are don't-care without their valid.
//  - Async reset mid-operation: immediate return to reset values, including clearing LOCKED.
// CONFIGURATION
//  ATM_AUTH_FACE_EN defined: high-value path is FACE_WAIT then OTP_WAIT, as above.
//  Not defined: FACE_WAIT is removed; high-value path goes AMT_WAIT -> OTP_WAIT; capture_face tied 0;
//  face_done and face_ok are unused.
// STRUCTURE
//  - Package atm_pkg:
//    - auth_state_t enum: IDLE, PIN_WAIT, AMT_WAIT, FACE_WAIT, OTP_WAIT, GRANT, DENY, LOCKED.
//    - Shared constants HIGH_VALUE_AMT_DEF and TIMEOUT_CYC_DEF.
//  - Sub-module atm_step_timer: clear/enable counter of width $clog2(TIMEOUT_CYC) with an expire flag;
//    cleared on every state change.
// TESTING
//  1 start, PIN ok, amount=500 -> auth_ok pulse 1 cycle; never capture_face or prompt_otp; busy ends.
//  2 start, PIN ok, amount=10001, face ok, OTP ok -> capture_face then prompt_otp then auth_ok.
//    Without ATM_AUTH_FACE_EN: prompt_otp directly.
//  3 amount=10000 -> GRANT directly (boundary not high-value).
//  4 three wrong PINs (MAX=3) -> tries_left 3,2,1,0; card_retain=1; one auth_fail.
//    A following start is ignored until reset is asserted low.
//  5 no PIN for TIMEOUT_CYC=8 cycles -> auth_fail on 9th cycle after entry.
//    pin_valid&match on the last count cycle -> AMT_WAIT, no fail.
//  6 abort during OTP_WAIT -> auth_fail next cycle, IDLE.
//    reset asserted in FACE_WAIT -> all outputs 0 and tries_left=3 immediately.

Source files
------------

// File: rtl/atm_pkg.sv
// -----------------------------------------------------------------------------
// atm_pkg
// Shared types and defaults for the ATM authentication sequencer.
//  - auth_state_t : authentication FSM states
//  - *_DEF        : default parameter values used by the sequencer and timer
//  - is_wait_state: true for states that wait on customer input and can time out
// -----------------------------------------------------------------------------
package atm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PIN_WAIT,
      AMT_WAIT,
      FACE_WAIT,
      OTP_WAIT,
      GRANT,
      DENY,
      LOCKED
   } auth_state_t;

   localparam int MAX_PIN_TRIES_DEF  = 3;
   localparam int HIGH_VALUE_AMT_DEF = 10000;
   localparam int TIMEOUT_CYC_DEF    = 1000;
   localparam int AMT_W_DEF          = 16;

   function automatic logic is_wait_state(input auth_state_t s);
      return (s == PIN_WAIT) || (s == AMT_WAIT) || (s == FACE_WAIT) || (s == OTP_WAIT);
   endfunction

endpackage

// File: rtl/atm_step_timer.sv
// -----------------------------------------------------------------------------
// atm_step_timer
// Per-step timeout counter for the authentication sequencer.
// Ports:
//  clk    in  rising-edge clock
//  reset  in  asynchronous, active-low reset
//  clear  in  restart the count at 0 on the next edge (priority over enable)
//  enable in  count one cycle
//  expire out count has reached TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module atm_step_timer
   import atm_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Saturate at the last count so the counter can never wrap back into range
   // if the owner holds it enabled past expiry.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != LAST_CNT)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = (count_q == LAST_CNT);

endmodule

// File: rtl/atm_auth_sequencer.sv
// -----------------------------------------------------------------------------
// atm_auth_sequencer
// Sequences customer authentication between card scan and transaction
// processing: PIN entry with retry limit, high-value face + OTP check,
// per-step timeout, card lockout, and a single grant/deny pulse.
// Build option: define ATM_AUTH_FACE_EN to include the FACE_WAIT step on the
// high-value path; without it high-value amounts go straight to OTP_WAIT,
// capture_face stays 0 and face_done/face_ok are ignored.
// Ports:
//  clk, reset (async active-low)
//  start, abort, pin_valid/pin_match, amount/amount_valid,
//  face_done/face_ok, otp_valid/otp_ok                     : inputs
//  prompt_pin, capture_face, prompt_otp, card_retain, busy  : level outputs
//  auth_ok, auth_fail                                       : 1-cycle pulses
//  tries_left                                               : PIN attempts left
// All outputs are registered.
// -----------------------------------------------------------------------------
module atm_auth_sequencer
   import atm_pkg::*;
#(
   parameter int MAX_PIN_TRIES  = MAX_PIN_TRIES_DEF,
   parameter int HIGH_VALUE_AMT = HIGH_VALUE_AMT_DEF,
   parameter int TIMEOUT_CYC    = TIMEOUT_CYC_DEF,
   parameter int AMT_W          = AMT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             pin_valid,
   input  logic             pin_match,
   input  logic [AMT_W-1:0] amount,
   input  logic             amount_valid,
   input  logic             face_done,
   input  logic             face_ok,
   input  logic             otp_valid,
   input  logic             otp_ok,
   output logic             prompt_pin,
   output logic             capture_face,
   output logic             prompt_otp,
   output logic             auth_ok,
   output logic             auth_fail,
   output logic             card_retain,
   output logic [2:0]       tries_left,
   output logic             busy
);

   localparam logic [2:0]       TRIES_INIT     = 3'(MAX_PIN_TRIES);
   localparam logic [AMT_W-1:0] HIGH_VALUE_LIM = AMT_W'(HIGH_VALUE_AMT);

   auth_state_t state_q, state_d;
   logic [2:0]  tries_left_q, tries_left_d;
   logic        prompt_pin_q, prompt_pin_d;
   logic        capture_face_q, capture_face_d;
   logic        prompt_otp_q, prompt_otp_d;
   logic        auth_ok_q, auth_ok_d;
   logic        auth_fail_q, auth_fail_d;
   logic        card_retain_q, card_retain_d;
   logic        busy_q, busy_d;

   logic        timer_clear;
   logic        timer_enable;
   logic        timer_expire;

`ifndef ATM_AUTH_FACE_EN
   logic unused_face_inputs;
   assign unused_face_inputs = face_done ^ face_ok;
`endif

   atm_step_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_step_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .enable (timer_enable),
      .expire (timer_expire)
   );

   // Next-state logic. In every wait state abort wins, then the qualifying
   // input, and the timeout only fires when neither is present.
   always_comb begin
      state_d      = state_q;
      tries_left_d = tries_left_q;
      timer_clear  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = PIN_WAIT;
               tries_left_d = TRIES_INIT;
            end
         end
         PIN_WAIT: begin
            if (abort) begin
               state_d = DENY;
            end else if (pin_valid) begin
               if (pin_match) begin
                  state_d = AMT_WAIT;
               end else begin
                  tries_left_d = tries_left_q - 3'd1;
                  if (tries_left_d == 3'd0) begin
                     state_d = LOCKED;
                  end else begin
                     // A retry gets a fresh timeout window.
                     timer_clear = 1'b1;
                  end
               end
            end else if (timer_expire) begin
               state_d = DENY;
            end
         end
         AMT_WAIT: begin
            if (abort) begin
               state_d = DENY;
            end else if (amount_valid) begin
               if (amount > HIGH_VALUE_LIM) begin
`ifdef ATM_AUTH_FACE_EN
                  state_d = FACE_WAIT;
`else
                  state_d = OTP_WAIT;
`endif
               end else begin
                  state_d = GRANT;
               end
            end else if (timer_expire) begin
               state_d = DENY;
            end
         end
`ifdef ATM_AUTH_FACE_EN
         FACE_WAIT: begin
            if (abort) begin
               state_d = DENY;
            end else if (face_done) begin
               state_d = face_ok ? OTP_WAIT : DENY;
            end else if (timer_expire) begin
               state_d = DENY;
            end
         end
`endif
         OTP_WAIT: begin
            if (abort) begin
               state_d = DENY;
            end else if (otp_valid) begin
               state_d = otp_ok ? GRANT : DENY;
            end else if (timer_expire) begin
               state_d = DENY;
            end
         end
         GRANT:   state_d = IDLE;
         DENY:    state_d = IDLE;
         LOCKED:  state_d = LOCKED;
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) begin
         timer_clear = 1'b1;
      end
      timer_enable = is_wait_state(state_q);
   end

   // Outputs are decoded from the next state so they appear registered,
   // one cycle after the input that caused the transition.
   always_comb begin
      prompt_pin_d   = (state_d == PIN_WAIT);
`ifdef ATM_AUTH_FACE_EN
      capture_face_d = (state_d == FACE_WAIT);
`else
      capture_face_d = 1'b0;
`endif
      prompt_otp_d   = (state_d == OTP_WAIT);
      auth_ok_d      = (state_d == GRANT);
      auth_fail_d    = (state_d == DENY) || ((state_d == LOCKED) && (state_q != LOCKED));
      card_retain_d  = (state_d == LOCKED);
      busy_d         = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         tries_left_q   <= TRIES_INIT;
         prompt_pin_q   <= 1'b0;
         capture_face_q <= 1'b0;
         prompt_otp_q   <= 1'b0;
         auth_ok_q      <= 1'b0;
         auth_fail_q    <= 1'b0;
         card_retain_q  <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         tries_left_q   <= tries_left_d;
         prompt_pin_q   <= prompt_pin_d;
         capture_face_q <= capture_face_d;
         prompt_otp_q   <= prompt_otp_d;
         auth_ok_q      <= auth_ok_d;
         auth_fail_q    <= auth_fail_d;
         card_retain_q  <= card_retain_d;
         busy_q         <= busy_d;
      end
   end

   assign prompt_pin   = prompt_pin_q;
   assign capture_face = capture_face_q;
   assign prompt_otp   = prompt_otp_q;
   assign auth_ok      = auth_ok_q;
   assign auth_fail    = auth_fail_q;
   assign card_retain  = card_retain_q;
   assign tries_left   = tries_left_q;
   assign busy         = busy_q;

endmodule
